datapath_pipe_bus: RTL

- Parametrised successor to the LEGv8 single-cycle datapath: register file, ALU, status register, PC and instruction register, with a width- and depth-generic core.
- Control words enter through a valid/ready handshake.
- Memory accesses use a req/ack bus with wait states instead of a combinational bus.
- Sits between the control unit (control word source) and the memory/bus fabric.

---
 rtl/datapath_pipe_bus_if.sv | 29 ++
 rtl/datapath_pipe_bus.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_pipe_bus_if.sv
// Control-word valid/ready handshake and req/ack memory bus of datapath_pipe_bus.
// master: the datapath side; slave: control unit plus memory fabric.
interface datapath_pipe_bus_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int CW_W   = 32,
    parameter int K_W    = 32
);
    logic              cw_valid;
    logic              cw_ready;
    logic [CW_W-1:0]   cw;
    logic [K_W-1:0]    k;
    logic              done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        input  cw_valid, cw, k, mem_rdata, mem_ack,
        output cw_ready, done, mem_req, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        output cw_valid, cw, k, mem_rdata, mem_ack,
        input  cw_ready, done, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/datapath_pipe_bus.sv
// Multicycle LEGv8-style datapath: control words via valid/ready, memory via req/ack.
// Optional bus timeout with sticky bus_err is enabled by defining DATAPATH_BUS_TIMEOUT_EN.
module datapath_pipe_bus #(
    parameter int                DATA_W      = 64,
    parameter int                ADDR_W      = 32,
    parameter int                NREGS       = 32,
    parameter int                RA_W        = $clog2(NREGS),
    parameter int                K_W         = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic                clock,
    input  logic                reset,
    datapath_pipe_bus_if.master bus,
    output logic [31:0]         IR_out,
    output logic [3:0]          status,
    output logic [ADDR_W-1:0]   pc,
    output logic                bus_err,
    input  logic [RA_W-1:0]     dbg_sel,
    output logic [DATA_W-1:0]   dbg_reg
);
    localparam int CW_W = 3*RA_W + 17;
    localparam int SH_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MEM_WAIT = 2'd2} state_t;

    state_t            state_r, state_nxt_s;
    logic [CW_W-1:0]   cw_r;
    logic [K_W-1:0]    k_r;
    logic [DATA_W-1:0] regs_r [NREGS];
    logic [31:0]       ir_r;
    logic [3:0]        status_r;
    logic [ADDR_W-1:0] pc_r;
    logic              done_r, mem_req_r, mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;

    logic              cw_ready_s, accept_s, issue_s, commit_s, abort_s, timeout_s;
    logic [2:0]        fs_s;
    logic [RA_W-1:0]   sa_s, sb_s, da_s;
    logic              w_reg_s, c0_s, mem_cs_s, b_sel_s, mem_w_s, ir_load_s;
    logic              status_load_s, add_sel_s, pc_sel_s, arith_s;
    logic [1:0]        data_sel_s, pc_fs_s;
    logic [DATA_W-1:0] a_s, b_reg_s, b_op_s, b_add_s, k_ext_s, alu_s, data_s;
    logic [DATA_W:0]   sum_s;
    logic [ADDR_W-1:0] k_addr_s, pc4_s, addr_s, pc_nxt_s;
    logic [3:0]        flags_s;
    logic              unused_s;

    assign fs_s = cw_r[CW_W-1 -: 3];
    assign sa_s = cw_r[CW_W-4 -: RA_W];
    assign sb_s = cw_r[CW_W-4-RA_W -: RA_W];
    assign da_s = cw_r[CW_W-4-2*RA_W -: RA_W];
    assign {w_reg_s, c0_s, mem_cs_s, b_sel_s, mem_w_s, ir_load_s, status_load_s,
            add_sel_s, data_sel_s, pc_sel_s, pc_fs_s} = cw_r[13:1];

    // The top register index reads as zero and is never written
    assign a_s      = (int'(sa_s) < NREGS-1) ? regs_r[sa_s] : '0;
    assign b_reg_s  = (int'(sb_s) < NREGS-1) ? regs_r[sb_s] : '0;
    assign dbg_reg  = (int'(dbg_sel) < NREGS-1) ? regs_r[dbg_sel] : '0;
    assign k_ext_s  = DATA_W'(k_r);
    assign k_addr_s = k_ext_s[ADDR_W-1:0];
    assign b_op_s   = b_sel_s ? k_ext_s : b_reg_s;
    assign pc4_s    = pc_r + ADDR_W'(4);
    assign unused_s = ^{cw_r[0], 32'(TIMEOUT_CYC)};

    // ALU result for the latched control word
    always_comb begin
        b_add_s = (fs_s == 3'd4) ? ~b_op_s : b_op_s;
        sum_s   = {1'b0, a_s} + {1'b0, b_add_s} + {{DATA_W{1'b0}}, c0_s};
        arith_s = (fs_s == 3'd3) || (fs_s == 3'd4);
        case (fs_s)
            3'd0:    alu_s = a_s & b_op_s;
            3'd1:    alu_s = a_s | b_op_s;
            3'd2:    alu_s = a_s ^ b_op_s;
            3'd3:    alu_s = sum_s[DATA_W-1:0];
            3'd4:    alu_s = sum_s[DATA_W-1:0];
            3'd5:    alu_s = b_op_s;
            3'd6:    alu_s = a_s << b_op_s[SH_W-1:0];
            3'd7:    alu_s = a_s >> b_op_s[SH_W-1:0];
            default: alu_s = '0;
        endcase
    end

    assign flags_s = {arith_s && (a_s[DATA_W-1] == b_add_s[DATA_W-1])
                              && (alu_s[DATA_W-1] != a_s[DATA_W-1]),
                      arith_s && sum_s[DATA_W],
                      alu_s[DATA_W-1],
                      (alu_s == '0)};
    assign addr_s  = add_sel_s ? pc_r : alu_s[ADDR_W-1:0];

    // Data-bus source and next PC
    always_comb begin
        case (data_sel_s)
            2'd0:    data_s = alu_s;
            2'd1:    data_s = b_reg_s;
            2'd2:    data_s = DATA_W'(pc4_s);
            2'd3:    data_s = mem_cs_s ? bus.mem_rdata : '0;
            default: data_s = '0;
        endcase
        case (pc_fs_s)
            2'd0:    pc_nxt_s = pc_r;
            2'd1:    pc_nxt_s = pc4_s;
            2'd2:    pc_nxt_s = pc_sel_s ? k_addr_s : a_s[ADDR_W-1:0];
            2'd3:    pc_nxt_s = pc_r + {k_addr_s[ADDR_W-3:0], 2'b00};
            default: pc_nxt_s = pc_r;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:     state_nxt_s = bus.cw_valid ? EXEC : IDLE;
            EXEC:     state_nxt_s = mem_cs_s ? MEM_WAIT : IDLE;
            MEM_WAIT: state_nxt_s = (bus.mem_ack || timeout_s) ? IDLE : MEM_WAIT;
            default:  state_nxt_s = IDLE;
        endcase
    end

    // FSM strobes; a completing ack always wins over a simultaneous timeout
    always_comb begin
        cw_ready_s = 1'b0;
        accept_s   = 1'b0;
        issue_s    = 1'b0;
        commit_s   = 1'b0;
        abort_s    = 1'b0;
        case (state_r)
            IDLE: begin
                cw_ready_s = 1'b1;
                accept_s   = bus.cw_valid;
            end
            EXEC: begin
                issue_s  = mem_cs_s;
                commit_s = !mem_cs_s;
            end
            MEM_WAIT: begin
                commit_s = bus.mem_ack;
                abort_s  = !bus.mem_ack && timeout_s;
            end
            default: cw_ready_s = 1'b0;
        endcase
    end

    // Latch the accepted control word and constant
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cw_r <= '0;
            k_r  <= '0;
        end else if (accept_s) begin
            cw_r <= bus.cw;
            k_r  <= bus.k;
        end
    end

    // Architectural state updated on commit; a timeout only moves the PC
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs_r[i] <= '0;
            ir_r     <= '0;
            status_r <= '0;
            pc_r     <= RESET_PC;
        end else begin
            if (commit_s && w_reg_s && (int'(da_s) < NREGS-1)) regs_r[da_s] <= data_s;
            if (commit_s && ir_load_s)     ir_r     <= data_s[31:0];
            if (commit_s && status_load_s) status_r <= flags_s;
            if (commit_s || abort_s)       pc_r     <= pc_nxt_s;
        end
    end

    // Bus request launched from EXEC and held until completion
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            done_r      <= 1'b0;
        end else begin
            done_r <= commit_s || abort_s;
            if (issue_s) begin
                mem_req_r   <= 1'b1;
                mem_we_r    <= mem_w_s;
                mem_addr_r  <= addr_s;
                mem_wdata_r <= b_reg_s;
            end else if (commit_s || abort_s) begin
                mem_req_r <= 1'b0;
            end
        end
    end

`ifdef DATAPATH_BUS_TIMEOUT_EN
    logic [31:0] wait_cnt_r;
    logic        bus_err_r;

    assign timeout_s = (wait_cnt_r == 32'(TIMEOUT_CYC - 1));
    assign bus_err   = bus_err_r;

    // Wait-cycle counter restarted by each new request; bus_err is sticky
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= '0;
            bus_err_r  <= 1'b0;
        end else begin
            if (issue_s)                   wait_cnt_r <= '0;
            else if (state_r == MEM_WAIT)  wait_cnt_r <= wait_cnt_r + 32'd1;
            if (abort_s)                   bus_err_r  <= 1'b1;
        end
    end
`else
    assign timeout_s = 1'b0;
    assign bus_err   = 1'b0;
`endif

    assign bus.cw_ready  = cw_ready_s;
    assign bus.done      = done_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign IR_out        = ir_r;
    assign status        = status_r;
    assign pc            = pc_r;
endmodule
